// File: rtl/render_queue.sv
// Command FIFO and sequencer feeding the graphics engine: queues tile draw
// commands, issues one render pulse per command, and waits for the engine's busy handshake.
module render_queue #(
  parameter int DEPTH         = 16,
  parameter int RENDER_LEN    = 2,
  parameter int START_TIMEOUT = 64
) (
  input  logic                     reset,
  input  logic                     nclk_100M,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [5:0]               cmd_x,
  input  logic [4:0]               cmd_y,
  input  logic [2:0]               cmd_id,
  input  logic                     flush,
  input  logic                     busy,
  output logic [5:0]               blk_x,
  output logic [4:0]               blk_y,
  output logic [2:0]               sprite_id,
  output logic                     render,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     idle,
  output logic                     bad_cmd,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(RENDER_LEN + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_WAIT_START = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [13:0]     mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [5:0]      blk_x_q, blk_x_d;
  logic [4:0]      blk_y_q, blk_y_d;
  logic [2:0]      sprite_id_q, sprite_id_d;
  logic            render_q, render_d;
  logic            ready_q, ready_d;
  logic            idle_q, idle_d;
  logic            bad_q, bad_d;
  logic            tmo_q, tmo_d;
  logic            push_fire_s, legal_s, wr_en_s, pop_s;
  logic [13:0]     head_entry_s;

  assign head_entry_s = mem_q[head_q];

  // Next-state logic for queue bookkeeping, sequencer and sticky flags.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pcnt_d      = pcnt_q;
    tcnt_d      = tcnt_q;
    blk_x_d     = blk_x_q;
    blk_y_d     = blk_y_q;
    sprite_id_d = sprite_id_q;
    render_d    = render_q;
    bad_d       = bad_q;
    tmo_d       = tmo_q;
    pop_s       = 1'b0;

    push_fire_s = cmd_valid && ready_q;
    legal_s     = (cmd_x <= 6'd39) && (cmd_y <= 5'd29) && (cmd_id <= 3'd4);
    wr_en_s     = push_fire_s && legal_s && !flush;

    if (push_fire_s && !legal_s) begin
      bad_d = 1'b1;
    end else begin
      bad_d = bad_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q != {CW{1'b0}})) begin
          blk_x_d     = head_entry_s[13:8];
          blk_y_d     = head_entry_s[7:3];
          sprite_id_d = head_entry_s[2:0];
          render_d    = 1'b1;
          pcnt_d      = PW'(RENDER_LEN - 1);
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      // The IDLE edge already counts as the first render cycle.
      S_ISSUE: begin
        if (pcnt_q == {PW{1'b0}}) begin
          render_d = 1'b0;
          tcnt_d   = {TW{1'b0}};
          state_d  = S_WAIT_START;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      S_WAIT_START: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == TW'(START_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          pop_s   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          pop_s   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        render_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // Flush keeps only the in-flight head; in IDLE nothing is in flight.
    if (flush) begin
      if (state_q == S_IDLE) begin
        tail_d  = head_q;
        count_d = {CW{1'b0}};
      end else if (pop_s) begin
        head_d  = head_q + AW'(1);
        tail_d  = head_q + AW'(1);
        count_d = {CW{1'b0}};
      end else begin
        tail_d  = head_q + AW'(1);
        count_d = CW'(1);
      end
    end else begin
      tail_d  = wr_en_s ? tail_q + AW'(1) : tail_q;
      head_d  = pop_s ? head_q + AW'(1) : head_q;
      count_d = count_q + CW'(wr_en_s) - CW'(pop_s);
    end

    ready_d = (count_d != CW'(DEPTH));
    idle_d  = (count_d == {CW{1'b0}}) && (state_d == S_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge nclk_100M or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      head_q      <= {AW{1'b0}};
      tail_q      <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      pcnt_q      <= {PW{1'b0}};
      tcnt_q      <= {TW{1'b0}};
      blk_x_q     <= 6'd0;
      blk_y_q     <= 5'd0;
      sprite_id_q <= 3'd0;
      render_q    <= 1'b0;
      ready_q     <= 1'b1;
      idle_q      <= 1'b1;
      bad_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pcnt_q      <= pcnt_d;
      tcnt_q      <= tcnt_d;
      blk_x_q     <= blk_x_d;
      blk_y_q     <= blk_y_d;
      sprite_id_q <= sprite_id_d;
      render_q    <= render_d;
      ready_q     <= ready_d;
      idle_q      <= idle_d;
      bad_q       <= bad_d;
      tmo_q       <= tmo_d;
    end
  end

  // Command storage; pointers alone define validity, so no reset needed.
  always_ff @(posedge nclk_100M) begin
    if (wr_en_s) begin
      mem_q[tail_q] <= {cmd_x, cmd_y, cmd_id};
    end
  end

  assign cmd_ready   = ready_q;
  assign blk_x       = blk_x_q;
  assign blk_y       = blk_y_q;
  assign sprite_id   = sprite_id_q;
  assign render      = render_q;
  assign q_count     = count_q;
  assign idle        = idle_q;
  assign bad_cmd     = bad_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_render_queue.sv
// Directed self-checking bench for render_queue with a small engine busy model.
module tb_render_queue;

  logic       reset, nclk_100M, cmd_valid, cmd_ready, flush, busy;
  logic [5:0] cmd_x, blk_x;
  logic [4:0] cmd_y, blk_y;
  logic [2:0] cmd_id, sprite_id;
  logic       render, idle, bad_cmd, timeout_err;
  logic [4:0] q_count;

  int n_checks = 0;
  int n_errors = 0;

  render_queue #(.DEPTH(16), .RENDER_LEN(2), .START_TIMEOUT(64)) dut (
    .reset(reset), .nclk_100M(nclk_100M), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_id(cmd_id), .flush(flush), .busy(busy),
    .blk_x(blk_x), .blk_y(blk_y), .sprite_id(sprite_id), .render(render),
    .q_count(q_count), .idle(idle), .bad_cmd(bad_cmd), .timeout_err(timeout_err)
  );

  initial nclk_100M = 1'b0;
  always #5 nclk_100M = ~nclk_100M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] x, input logic [4:0] y, input logic [2:0] id);
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_id = id;
    @(negedge nclk_100M);
    cmd_valid = 1'b0;
  endtask

  // Waits for a render pulse, checks its length and the held command fields.
  task automatic wait_pulse(input logic [5:0] ex, input logic [4:0] ey, input logic [2:0] eid);
    int k = 0;
    int hi = 0;
    logic ok = 1'b1;
    while (!render && k < 200) begin
      @(negedge nclk_100M);
      k++;
    end
    check("render_rise", 32'(render), 32'd1);
    while (render && hi < 20) begin
      if (blk_x !== ex || blk_y !== ey || sprite_id !== eid) ok = 1'b0;
      hi++;
      @(negedge nclk_100M);
    end
    check("render_len", hi, 32'd2);
    check("blk_x", 32'(blk_x), 32'(ex));
    check("blk_y", 32'(blk_y), 32'(ey));
    check("sprite_id", 32'(sprite_id), 32'(eid));
    check("pulse_stable", 32'(ok), 32'd1);
  endtask

  // Full command: pulse, busy raised right after render falls, then released.
  task automatic issue_one(input logic [5:0] ex, input logic [4:0] ey, input logic [2:0] eid,
                           input int busy_len, input int exp_cnt);
    logic ok = 1'b1;
    wait_pulse(ex, ey, eid);
    busy = 1'b1;
    repeat (busy_len) begin
      @(negedge nclk_100M);
      if (render || blk_x !== ex || blk_y !== ey || sprite_id !== eid) ok = 1'b0;
    end
    check("busy_stable", 32'(ok), 32'd1);
    check("count_before_pop", 32'(q_count), 32'(exp_cnt));
    busy = 1'b0;
    @(negedge nclk_100M);
    check("count_after_pop", 32'(q_count), 32'(exp_cnt - 1));
  endtask

  task automatic no_render(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge nclk_100M);
      if (render) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    reset = 1'b0; cmd_valid = 1'b0; cmd_x = 6'd0; cmd_y = 5'd0; cmd_id = 3'd0;
    flush = 1'b0; busy = 1'b0;
    #3 reset = 1'b1;
    repeat (2) @(negedge nclk_100M);
    reset = 1'b0;
    @(negedge nclk_100M);
    check("rst_render", 32'(render), 32'd0);
    check("rst_blk_x", 32'(blk_x), 32'd0);
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_bad", 32'(bad_cmd), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);

    // Single command
    push(6'd12, 5'd7, 3'd3);
    check("t1_count", 32'(q_count), 32'd1);
    issue_one(6'd12, 5'd7, 3'd3, 64, 1);
    check("t1_idle", 32'(idle), 32'd1);

    // Fill to full with the engine stuck busy
    busy = 1'b1;
    for (int i = 0; i < 16; i++) push(6'(i + 3), 5'(i + 1), 3'(i % 5));
    check("t2_ready_full", 32'(cmd_ready), 32'd0);
    check("t2_count_full", 32'(q_count), 32'd16);
    check("t2_head_x", 32'(blk_x), 32'd3);
    push(6'd33, 5'd3, 3'd1);
    check("t2_17th_count", 32'(q_count), 32'd16);
    busy = 1'b0;
    @(negedge nclk_100M);
    check("t2_ready_after_pop", 32'(cmd_ready), 32'd1);
    check("t2_count_after_pop", 32'(q_count), 32'd15);
    for (int i = 1; i < 16; i++) issue_one(6'(i + 3), 5'(i + 1), 3'(i % 5), 3, 16 - i);
    check("t2_empty", 32'(q_count), 32'd0);
    check("t2_idle", 32'(idle), 32'd1);
    check("t2_no_bad", 32'(bad_cmd), 32'd0);

    // Illegal commands
    push(6'd40, 5'd0, 3'd3);
    push(6'd0, 5'd30, 3'd4);
    push(6'd0, 5'd0, 3'd5);
    no_render("t3_no_render", 10);
    check("t3_bad", 32'(bad_cmd), 32'd1);
    check("t3_count", 32'(q_count), 32'd0);

    // Engine never starts
    check("t4_tmo_before", 32'(timeout_err), 32'd0);
    push(6'd5, 5'd5, 3'd1);
    push(6'd6, 5'd6, 3'd2);
    wait_pulse(6'd5, 5'd5, 3'd1);
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge nclk_100M);
      n++;
    end
    check("t4_tmo_cycles", n, 32'd64);
    check("t4_count", 32'(q_count), 32'd1);
    issue_one(6'd6, 5'd6, 3'd2, 4, 1);
    check("t4_tmo_sticky", 32'(timeout_err), 32'd1);

    // Flush during WAIT_DONE of the first command
    busy = 1'b1;
    for (int i = 0; i < 5; i++) push(6'(10 + i), 5'(i), 3'(i % 5));
    repeat (2) @(negedge nclk_100M);
    check("t5_count", 32'(q_count), 32'd5);
    check("t5_head_x", 32'(blk_x), 32'd10);
    flush = 1'b1;
    @(negedge nclk_100M);
    flush = 1'b0;
    check("t5_count_flush", 32'(q_count), 32'd1);
    busy = 1'b0;
    @(negedge nclk_100M);
    check("t5_count_done", 32'(q_count), 32'd0);
    no_render("t5_no_render", 20);
    check("t5_idle", 32'(idle), 32'd1);

    // Reset while render is high
    push(6'd9, 5'd9, 3'd0);
    k = 0;
    while (!render && k < 10) begin
      @(negedge nclk_100M);
      k++;
    end
    check("t6_render_up", 32'(render), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_render", 32'(render), 32'd0);
    check("t6_count", 32'(q_count), 32'd0);
    check("t6_bad", 32'(bad_cmd), 32'd0);
    check("t6_tmo", 32'(timeout_err), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    check("t6_blk_x", 32'(blk_x), 32'd0);
    @(negedge nclk_100M);
    reset = 1'b0;
    @(negedge nclk_100M);
    push(6'd20, 5'd10, 3'd2);
    issue_one(6'd20, 5'd10, 3'd2, 5, 1);
    check("t6_idle_end", 32'(idle), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/render_queue.md
Name: render_queue

Overview:
- Command FIFO and sequencer directly upstream of the graphics engine.
- Game logic pushes draw commands (tile x, tile y, sprite id). The block issues them one at a time to the engine's blk_x/blk_y/sprite_id/render inputs.
- Holds each command stable until the engine's busy falls, then moves to the next.
- Rejects illegal commands and recovers from an engine that never starts.

Parameters:
- DEPTH, 16: FIFO entries; power of two, min 2.
- RENDER_LEN, 2: cycles render is held high per command; must be ≥1.
- START_TIMEOUT, 64: cycles to wait for busy to rise after render falls.

Ports:
- reset  in  1  async active-high reset
- nclk_100M  in  1  clock (inverted 100 MHz); all state on its rising edge
- cmd_valid  in  1  push request
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_x  in  6  tile x, 0-39
- cmd_y  in  5  tile y, 0-29
- cmd_id  in  3  sprite id, 0-4
- flush  in  1  sync clear of queued (not in-flight) commands
- busy  in  1  engine busy
- blk_x  out  6  to engine
- blk_y  out  5  to engine
- sprite_id  out  3  to engine
- render  out  1  to engine
- q_count  out  $clog2(DEPTH)+1  entries stored, including the in-flight one
- idle  out  1  FIFO empty and FSM in IDLE
- bad_cmd  out  1  sticky: illegal command dropped
- timeout_err  out  1  sticky: engine failed to start

Behaviour:
- Reset (async): FIFO empty; FSM=IDLE; render=0; blk_x=0, blk_y=0, sprite_id=0; bad_cmd=0, timeout_err=0; idle=1; cmd_ready=1.
- Push:
  - Occurs when cmd_valid && cmd_ready at a clock edge.
  - Legal command (x≤39, y≤29, id≤4) is written to tail.
  - Illegal command is not stored, sets bad_cmd, and still consumes the handshake.
  - cmd_ready derives from registered count only. When full it stays 0 even if a pop happens the same cycle; no same-cycle refill.
- FSM, one head entry at a time:
  - IDLE: if not empty, latch head into blk_x/blk_y/sprite_id, assert render, load the pulse counter, go ISSUE.
  - ISSUE: render=1 for exactly RENDER_LEN cycles, counted from the IDLE edge. Then render=0, go WAIT_START.
  - WAIT_START: busy=1 -> WAIT_DONE. If START_TIMEOUT cycles elapse, set timeout_err, pop head, go IDLE.
  - WAIT_DONE: busy=0 -> pop head, go IDLE.
- Command outputs never change between leaving IDLE and the next return to IDLE; the engine reads them combinationally during busy.
- At least one IDLE cycle separates consecutive render pulses. Minimum per-command cost is RENDER_LEN+3 cycles plus the busy time.
- Pop decrements count. Simultaneous push and pop leaves count unchanged, with both pointers advancing. Pointers wrap modulo DEPTH.
- q_count includes the in-flight entry until it is popped.
- flush, synchronous:
  - Outside IDLE: discards all entries except the head; count becomes 1.
  - In IDLE: empties the FIFO and no command issues that cycle.
  - A push in the same cycle as flush is discarded.
- Sticky flags clear only on reset.
- Reset mid-operation (render high or busy pending) returns to the reset state immediately. render drops asynchronously.

Test Plan:
- Single command (12,7,3) pushed, engine model raises busy 1 cycle after render falls and holds it 64 cycles -> render high 2 cycles; blk_x=12, blk_y=7, sprite_id=3 stable throughout; q_count 1→0 on the busy-fall edge; idle=1 afterwards.
- Push 16 commands back-to-back with busy stuck high -> cmd_ready=0 after the 16th; 17th not accepted. Release busy -> cmd_ready=1 the cycle after the pop; commands issue in FIFO order.
- Push (40,0,3), (0,30,4), (0,0,5) -> none issued; bad_cmd=1; q_count=0.
- Busy never rises -> timeout_err=1 exactly 64 cycles after render falls; entry popped; next command issues normally.
- Queue 5 commands, flush during the first command's WAIT_DONE -> the in-flight command completes; q_count=1 then 0; no further render pulses.
- Assert reset while render is high -> render=0, q_count=0, flags 0 immediately; a new push after reset issues correctly.
